// File: rtl/line_shift_ram_nx.sv
// line_shift_ram_nx: raster line buffer that emits a vertical column of LINES
// pixels (current pixel plus LINES-1 lines above) per valid input pixel.
// Previous lines live in LINES-1 simple-dual-port RAM banks that shift one
// line down every line via read-before-write at the same column address.
// The column appears two cycles after the input, with the sync signals
// delayed to match. Lines missing at the top of a frame are border-masked.
module line_shift_ram_nx #(
    parameter int DATA_W      = 8,
    parameter int IMG_HDISP   = 640,
    parameter int LINES       = 3,
    parameter int ADDR_W      = 10,
    parameter int BORDER_MODE = 0
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic                    pre_frame_vsync,
    input  logic                    pre_frame_href,
    input  logic                    clken,
    input  logic [DATA_W-1:0]       shiftin,
    output logic                    post_frame_vsync,
    output logic                    post_frame_href,
    output logic                    post_clken,
    output logic [LINES*DATA_W-1:0] taps,
    output logic [2:0]              lines_filled,
    output logic                    ovf
);

    localparam int BANKS = LINES - 1;
    localparam int DEPTH = 1 << ADDR_W;
    // One extra bit so the column count can reach IMG_HDISP even when
    // IMG_HDISP equals 2^ADDR_W; the RAM address uses the low ADDR_W bits.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] HDISP_C = CNT_W'(IMG_HDISP);
    localparam logic [2:0]       LF_MAX  = 3'(LINES - 1);

    // Saturating increment of the stored-line count.
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v >= LF_MAX) ? LF_MAX : v + 3'd1;
    endfunction

    // Replace taps above the stored-line count with zero or with the oldest
    // valid tap, depending on the border mode.
    function automatic logic [LINES*DATA_W-1:0] border_mask(
        input logic [LINES*DATA_W-1:0] col_in,
        input logic [2:0]              lf
    );
        logic [LINES*DATA_W-1:0] r;
        logic [DATA_W-1:0]       rep;
        r   = col_in;
        rep = '0;
        for (int k = 0; k < LINES; k++) begin
            if (3'(k) == lf) rep = col_in[k*DATA_W +: DATA_W];
        end
        for (int k = 1; k < LINES; k++) begin
            if (3'(k) > lf) begin
                r[k*DATA_W +: DATA_W] = (BORDER_MODE == 1) ? rep : '0;
            end
        end
        return r;
    endfunction

    // Control state
    logic [CNT_W-1:0] col;
    logic             armed;
    logic             line_acc;

    // Stage p1 registers
    logic                    vld_p1;
    logic                    acc_p1;
    logic                    href_p1;
    logic                    vsync_p1;
    logic [DATA_W-1:0]       pix_p1;
    logic [ADDR_W-1:0]       wr_addr_p1;
    logic [2:0]              lf_p1;
    logic [BANKS*DATA_W-1:0] rd_p1;

    // ---- stage p0: input qualification and edge detection ----
    logic              vld_p0;
    logic              in_range_p0;
    logic              acc_p0;
    logic              ovf_p0;
    logic              line_end_p0;
    logic              frame_start_p0;
    logic [ADDR_W-1:0] rd_addr_p0;

    assign vld_p0         = pre_frame_href & clken;
    assign in_range_p0    = (col < HDISP_C);
    // Pixels of a line already in progress when reset released are ignored
    // until href drops, so the block restarts cleanly on the next line.
    assign acc_p0         = vld_p0 & in_range_p0 & armed;
    assign ovf_p0         = vld_p0 & ~in_range_p0 & armed;
    assign line_end_p0    = href_p1 & ~pre_frame_href;
    assign frame_start_p0 = pre_frame_vsync & ~vsync_p1;
    assign rd_addr_p0     = col[ADDR_W-1:0];

    // Column counter: restarts each line, advances on accepted pixels only.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            col <= '0;
        end else if (!pre_frame_href) begin
            col <= '0;
        end else if (acc_p0) begin
            col <= col + CNT_W'(1);
        end
    end

    // Line/frame bookkeeping: stored-line count, overflow flag, line arming.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            lines_filled <= '0;
            ovf          <= 1'b0;
            line_acc     <= 1'b0;
            armed        <= 1'b0;
        end else begin
            if (frame_start_p0) begin
                lines_filled <= '0;
                ovf          <= 1'b0;
            end else begin
                if (line_end_p0 && line_acc) lines_filled <= sat_inc(lines_filled);
                if (ovf_p0) ovf <= 1'b1;
            end
            if (!pre_frame_href) begin
                line_acc <= 1'b0;
                armed    <= 1'b1;
            end else if (acc_p0) begin
                line_acc <= 1'b1;
            end
        end
    end

    // ---- stage p1: control pipe (sync delays, valid, write enable) ----
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            acc_p1   <= 1'b0;
            href_p1  <= 1'b0;
            vsync_p1 <= 1'b0;
        end else begin
            vld_p1   <= vld_p0;
            acc_p1   <= acc_p0;
            href_p1  <= pre_frame_href;
            vsync_p1 <= pre_frame_vsync;
        end
    end

    // Data pipe alongside the RAM read: pixel, write address, line count.
    always_ff @(posedge clock) begin
        pix_p1     <= shiftin;
        wr_addr_p1 <= rd_addr_p0;
        lf_p1      <= lines_filled;
    end

    // Line banks: bank 0 takes the new pixel, bank k takes bank k-1's old
    // value at the same column, written one cycle after the read.
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] rd_q;
        logic [DATA_W-1:0] wr_data;

        if (b == 0) begin : g_head
            assign wr_data = pix_p1;
        end else begin : g_chain
            assign wr_data = rd_p1[(b-1)*DATA_W +: DATA_W];
        end

        // Registered read at the current column, delayed write of the shift.
        always_ff @(posedge clock) begin
            if (acc_p1) mem[wr_addr_p1] <= wr_data;
            rd_q <= mem[rd_addr_p0];
        end

        assign rd_p1[b*DATA_W +: DATA_W] = rd_q;
    end

    // ---- stage p2: border-masked column and delayed syncs ----
    logic [LINES*DATA_W-1:0] col_p1;
    assign col_p1 = {rd_p1, pix_p1};

    // Output register: taps update only on valid pixels and hold otherwise.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_clken       <= 1'b0;
            taps             <= '0;
        end else begin
            post_frame_vsync <= vsync_p1;
            post_frame_href  <= href_p1;
            post_clken       <= vld_p1;
            if (vld_p1) taps <= border_mask(col_p1, lf_p1);
        end
    end

endmodule

// File: tb/tb_line_shift_ram_nx.sv
// Directed bench for line_shift_ram_nx: two instances (zero-fill and
// replicate borders) share one stimulus stream of 8-pixel ramp lines where
// line L pixel c = 16L+c. Output columns are collected per line and compared
// against hand-computed values.
module tb_line_shift_ram_nx;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        vsync;
    logic        href;
    logic        clken;
    logic [7:0]  shiftin;

    logic        pv0, ph0, pc0, ovf0;
    logic        pv1, ph1, pc1, ovf1;
    logic [23:0] taps0, taps1;
    logic [2:0]  lf0, lf1;

    int total = 0;
    int bad   = 0;

    logic [31:0] pat = 32'hB34E_96CB;
    int          exp_lf [4] = '{0, 1, 2, 2};

    // Collected output columns, indexed [line][column]
    logic [23:0] cap0 [8][16];
    logic [23:0] cap1 [8][16];
    int          cnt  [8];
    int          ln = 0;
    int          cc = 0;
    logic        pv_q = 1'b0;
    logic        ph_q = 1'b0;

    always #5 clock = ~clock;

    line_shift_ram_nx #(
        .DATA_W(8), .IMG_HDISP(8), .LINES(3), .ADDR_W(3), .BORDER_MODE(0)
    ) dut0 (
        .clock(clock), .rst_n(rst_n), .pre_frame_vsync(vsync),
        .pre_frame_href(href), .clken(clken), .shiftin(shiftin),
        .post_frame_vsync(pv0), .post_frame_href(ph0), .post_clken(pc0),
        .taps(taps0), .lines_filled(lf0), .ovf(ovf0)
    );

    line_shift_ram_nx #(
        .DATA_W(8), .IMG_HDISP(8), .LINES(3), .ADDR_W(3), .BORDER_MODE(1)
    ) dut1 (
        .clock(clock), .rst_n(rst_n), .pre_frame_vsync(vsync),
        .pre_frame_href(href), .clken(clken), .shiftin(shiftin),
        .post_frame_vsync(pv1), .post_frame_href(ph1), .post_clken(pc1),
        .taps(taps1), .lines_filled(lf1), .ovf(ovf1)
    );

    // Collect output columns per line; a post vsync rise restarts indexing.
    always @(negedge clock) begin
        if (pv0 && !pv_q) begin
            ln = 0;
            cc = 0;
        end else if (!ph0 && ph_q) begin
            cnt[ln] = cc;
            if (ln < 7) ln++;
            cc = 0;
        end
        if (pc0) begin
            cap0[ln][cc] = taps0;
            cap1[ln][cc] = taps1;
            if (cc < 15) cc++;
        end
        pv_q = pv0;
        ph_q = ph0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic send_line(input int L, input int npix, input bit gapped,
                             input bit chk_lat, input logic [23:0] exp0);
        int c;
        int i;
        c = 0;
        i = 0;
        href = 1'b1;
        while (c < npix) begin
            clken   = gapped ? pat[i % 32] : 1'b1;
            shiftin = 8'(16 * L + c);
            cyc();
            if (chk_lat && i == 0) begin
                chk("lat_clken_t1", 32'(pc0), 32'd0);
                chk("lat_href_t1", 32'(ph0), 32'd0);
            end
            if (chk_lat && i == 1) begin
                chk("lat_clken_t2", 32'(pc0), 32'd1);
                chk("lat_href_t2", 32'(ph0), 32'd1);
                chk("lat_taps_t2", 32'(taps0), 32'(exp0));
            end
            if (clken) c++;
            i++;
        end
        href  = 1'b0;
        clken = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        cyc();
        cyc();
        vsync = 1'b0;
        cyc();
    endtask

    initial begin
        rst_n   = 1'b0;
        vsync   = 1'b0;
        href    = 1'b0;
        clken   = 1'b0;
        shiftin = '0;
        repeat (3) cyc();
        chk("rst_taps", 32'(taps0), 32'd0);
        chk("rst_clken", 32'(pc0), 32'd0);
        chk("rst_lf", 32'(lf0), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Stream before any frame start: one overflowing line, then a
        // partial line interrupted by reset.
        send_line(10, 10, 1'b0, 1'b0, 24'h0);
        chk("pre_ovf", 32'(ovf0), 32'd1);
        chk("pre_lf", 32'(lf0), 32'd1);
        href    = 1'b1;
        clken   = 1'b1;
        shiftin = 8'hC0;
        cyc();
        cyc();
        chk("pre_clken", 32'(pc0), 32'd1);
        rst_n = 1'b0;
        cyc();
        chk("mid_rst_taps", 32'(taps0), 32'd0);
        chk("mid_rst_clken", 32'(pc0), 32'd0);
        chk("mid_rst_href", 32'(ph0), 32'd0);
        chk("mid_rst_vsync", 32'(pv0), 32'd0);
        chk("mid_rst_lf", 32'(lf0), 32'd0);
        chk("mid_rst_ovf", 32'(ovf0), 32'd0);
        chk("mid_rst_d1", {26'd0, pv1, ph1, pc1, lf1}, 32'd0);
        chk("mid_rst_d1_ovf", 32'(ovf1), 32'd0);
        cyc();
        rst_n = 1'b1;
        href  = 1'b0;
        clken = 1'b0;
        cyc();
        cyc();

        // Frame A: four ramp lines, clken always high
        vsync = 1'b1;
        cyc();
        chk("vsync_lat_t1", 32'(pv0), 32'd0);
        cyc();
        chk("vsync_lat_t2", 32'(pv0), 32'd1);
        vsync = 1'b0;
        cyc();
        for (int L = 0; L < 4; L++) begin
            chk($sformatf("A_lf_line%0d", L), 32'(lf0), 32'(exp_lf[L]));
            send_line(L, 8, 1'b0, (L == 2), 24'h001020);
        end
        cyc();
        chk("A_cnt_line0", 32'(cnt[0]), 32'd8);
        chk("A_z_l0c5", 32'(cap0[0][5]), 32'h000005);
        chk("A_z_l1c2", 32'(cap0[1][2]), 32'h000212);
        chk("A_z_l2c3", 32'(cap0[2][3]), 32'h031323);
        chk("A_z_l3c7", 32'(cap0[3][7]), 32'h172737);
        chk("A_r_l0c5", 32'(cap1[0][5]), 32'h050505);
        chk("A_r_l1c0", 32'(cap1[1][0]), 32'h000010);
        chk("A_r_l2c3", 32'(cap1[2][3]), 32'h031323);
        chk("A_r_lf", 32'(lf1), 32'd2);

        // Frame B: new frame over stale RAM, gapped clken
        vsync = 1'b1;
        cyc();
        chk("B_lf_clear", 32'(lf0), 32'd0);
        cyc();
        vsync = 1'b0;
        cyc();
        for (int L = 0; L < 3; L++) send_line(L, 8, 1'b1, 1'b0, 24'h0);
        cyc();
        chk("B_cnt_line0", 32'(cnt[0]), 32'd8);
        chk("B_cnt_line1", 32'(cnt[1]), 32'd8);
        chk("B_cnt_line2", 32'(cnt[2]), 32'd8);
        chk("B_z_l0c4", 32'(cap0[0][4]), 32'h000004);
        chk("B_z_l1c4", 32'(cap0[1][4]), 32'h000414);
        chk("B_z_l2c3", 32'(cap0[2][3]), 32'h031323);
        chk("B_r_l0c4", 32'(cap1[0][4]), 32'h040404);
        chk("B_r_l2c3", 32'(cap1[2][3]), 32'h031323);

        // Frame C: overflowing line, then vsync rise coinciding with href fall
        frame_start();
        href  = 1'b1;
        clken = 1'b1;
        for (int c = 0; c < 10; c++) begin
            shiftin = 8'(c);
            cyc();
            if (c == 7) chk("C_ovf_8th", 32'(ovf0), 32'd0);
            if (c == 8) chk("C_ovf_9th", 32'(ovf0), 32'd1);
        end
        href  = 1'b0;
        clken = 1'b0;
        cyc();
        cyc();
        chk("C_lf_line1", 32'(lf0), 32'd1);
        send_line(1, 8, 1'b0, 1'b0, 24'h0);
        chk("C_ovf_sticky", 32'(ovf0), 32'd1);
        chk("C_lf_line2", 32'(lf0), 32'd2);
        href  = 1'b1;
        clken = 1'b1;
        for (int c = 0; c < 3; c++) begin
            shiftin = 8'(32 + c);
            cyc();
        end
        vsync = 1'b1;
        href  = 1'b0;
        clken = 1'b0;
        cyc();
        chk("C_vsync_wins_lf", 32'(lf0), 32'd0);
        chk("C_ovf_cleared", 32'(ovf0), 32'd0);
        vsync = 1'b0;
        cyc();
        cyc();
        chk("C_cnt_line0", 32'(cnt[0]), 32'd10);
        chk("C_z_l1c0", 32'(cap0[1][0]), 32'h000010);
        chk("C_z_l1c7", 32'(cap0[1][7]), 32'h000717);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
